// File: rtl/vec_seq_pkg.sv
// Shared definitions for the vector sequencing controller: FSM states,
// vtype field positions, SEW/LMUL encodings and beat geometry.
package vec_seq_pkg;

    localparam int XLEN_DEF      = 32;
    localparam int VLEN_DEF      = 512;
    localparam int LANE_W_DEF    = 128;
    localparam int BEATS_PER_REG = VLEN_DEF / LANE_W_DEF;
    localparam int VLMAX_ABS     = VLEN_DEF * 8 / 8;

    localparam int VLMUL_LSB = 0;
    localparam int VLMUL_MSB = 2;
    localparam int VSEW_LSB  = 3;
    localparam int VSEW_MSB  = 5;
    localparam int VTA_BIT   = 6;
    localparam int VMA_BIT   = 7;
    localparam int VILL_BIT  = XLEN_DEF - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONF = 2'd1,
        ST_WB   = 2'd2,
        ST_EXEC = 2'd3
    } seq_state_t;

    typedef enum logic [2:0] {
        SEW_8  = 3'b000,
        SEW_16 = 3'b001,
        SEW_32 = 3'b010
    } vsew_t;

    typedef enum logic [2:0] {
        LMUL_1 = 3'b000,
        LMUL_2 = 3'b001,
        LMUL_4 = 3'b010,
        LMUL_8 = 3'b011
    } vlmul_t;

    function automatic logic sew_legal(input logic [2:0] sew);
        return sew <= SEW_32;
    endfunction

    function automatic logic lmul_legal(input logic [2:0] lmul);
        return lmul <= LMUL_8;
    endfunction

endpackage

// File: rtl/vec_vlmax_calc.sv
// Combinational vtype check: flags unsupported SEW/LMUL or nonzero reserved
// bits as vill, otherwise returns VLMAX = VLEN*LMUL/SEW.
// The vill bit of the requested vtype is not an input; legality is decided
// purely from the other fields.
module vec_vlmax_calc
    import vec_seq_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int VLEN = 512
) (
    input  logic [XLEN-2:0] vtype,
    output logic [XLEN-1:0] vlmax,
    output logic            vill
);

    logic [2:0] vlmul;
    logic [2:0] vsew;

    assign vlmul = vtype[VLMUL_MSB:VLMUL_LSB];
    assign vsew  = vtype[VSEW_MSB:VSEW_LSB];

    // Legal settings scale VLEN up by LMUL and down by SEW; anything else is vill with VLMAX 0
    always_comb begin
        vill  = 1'b1;
        vlmax = '0;
        if (lmul_legal(vlmul) && sew_legal(vsew) && (vtype[XLEN-2:VMA_BIT+1] == '0)) begin
            vill  = 1'b0;
            vlmax = (XLEN'(VLEN) << vlmul[1:0]) >> (vsew + 3'd3);
        end
    end

endmodule

// File: rtl/vec_seq_ctrl.sv
// Vector sequencing controller: owns vl/vtype, executes vset{i}vl{i} with a
// vl writeback handshake, and slices arithmetic ops into LANE_W-bit beats
// walking the register group.
// Build option: define VEC_SEQ_PERF_EN to enable the perf_beats/perf_stalls
// counters; without it both ports are tied to zero.
module vec_seq_ctrl
    import vec_seq_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int VLEN   = 512,
    parameter int LANE_W = 128
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        inst_valid,
    output logic                        inst_ready,
    input  logic                        is_conf,
    input  logic [XLEN-1:0]             avl_i,
    input  logic [XLEN-1:0]             vtype_i,
    input  logic                        rs1_x0,
    input  logic                        rd_x0,
    input  logic [4:0]                  vd_i,
    input  logic [4:0]                  vs1_i,
    input  logic [4:0]                  vs2_i,
    output logic [XLEN-1:0]             vl_o,
    output logic [XLEN-1:0]             vtype_o,
    output logic                        wb_valid,
    input  logic                        wb_ready,
    output logic [XLEN-1:0]             wb_data,
    output logic                        beat_valid,
    input  logic                        beat_ready,
    output logic [4:0]                  beat_vd,
    output logic [4:0]                  beat_vs1,
    output logic [4:0]                  beat_vs2,
    output logic [1:0]                  beat_sub,
    output logic [$clog2(LANE_W/8):0]   beat_elems,
    output logic [2:0]                  beat_sew,
    output logic                        inst_done,
    output logic                        illegal,
    output logic [31:0]                 perf_beats,
    output logic [31:0]                 perf_stalls
);

    localparam int BPR       = VLEN / LANE_W;
    localparam int LANE_LOG2 = $clog2(LANE_W);
    localparam int ELEM_W    = $clog2(LANE_W/8) + 1;
    localparam int CNT_W     = 8;

    seq_state_t        state;
    logic [XLEN-1:0]   vl_q;
    logic [XLEN-1:0]   vtype_q;
    logic [XLEN-1:0]   avl_q;
    logic [XLEN-2:0]   req_vtype_q;
    logic              rs1_x0_q;
    logic              rd_x0_q;
    logic [4:0]        vd_q;
    logic [4:0]        vs1_q;
    logic [4:0]        vs2_q;
    logic [CNT_W-1:0]  beat_cnt;
    logic              beat_last;

    logic [XLEN-1:0]   conf_vlmax;
    logic              conf_vill;
    logic [XLEN-1:0]   conf_vl;

    logic [2:0]        epb_shift;
    logic [XLEN-1:0]   epb;
    logic [XLEN-1:0]   total_beats;
    logic [CNT_W-1:0]  nb;
    logic [4:0]        base_vd;
    logic [4:0]        base_vs1;
    logic [4:0]        base_vs2;
    logic [4:0]        nb_vd;
    logic [4:0]        nb_vs1;
    logic [4:0]        nb_vs2;
    logic [1:0]        nb_sub;
    logic [ELEM_W-1:0] nb_elems;
    logic              nb_last;
    logic              req_vill_unused;

    // The requested vill bit carries no meaning; legality comes from the other fields
    assign req_vill_unused = vtype_i[XLEN-1];

    assign inst_ready = (state == ST_IDLE);
    assign vl_o       = vl_q;
    assign vtype_o    = vtype_q;
    assign wb_data    = vl_q;
    assign beat_sew   = vtype_q[VSEW_MSB:VSEW_LSB];

    vec_vlmax_calc #(
        .XLEN (XLEN),
        .VLEN (VLEN)
    ) u_vlmax_calc (
        .vtype (req_vtype_q),
        .vlmax (conf_vlmax),
        .vill  (conf_vill)
    );

    // New vl for a configuration op: illegal clears it, x0 forms pick VLMAX or keep vl, else clamp AVL
    always_comb begin
        conf_vl = '0;
        if (conf_vill) begin
            conf_vl = '0;
        end else if (rs1_x0_q && !rd_x0_q) begin
            conf_vl = conf_vlmax;
        end else if (rs1_x0_q && rd_x0_q) begin
            conf_vl = vl_q;
        end else if (avl_q < conf_vlmax) begin
            conf_vl = avl_q;
        end else begin
            conf_vl = conf_vlmax;
        end
    end

    // Fields of the beat that will be presented next: beat 0 at acceptance, beat_cnt+1 while executing
    always_comb begin
        epb_shift   = 3'(LANE_LOG2 - 3) - beat_sew;
        epb         = XLEN'(1) << epb_shift;
        total_beats = (vl_q + epb - XLEN'(1)) >> epb_shift;
        if (state == ST_EXEC) begin
            nb       = beat_cnt + CNT_W'(1);
            base_vd  = vd_q;
            base_vs1 = vs1_q;
            base_vs2 = vs2_q;
        end else begin
            nb       = '0;
            base_vd  = vd_i;
            base_vs1 = vs1_i;
            base_vs2 = vs2_i;
        end
        nb_vd    = base_vd  + 5'(nb / BPR);
        nb_vs1   = base_vs1 + 5'(nb / BPR);
        nb_vs2   = base_vs2 + 5'(nb / BPR);
        nb_sub   = 2'(nb % BPR);
        nb_last  = ((XLEN'(nb) + XLEN'(1)) == total_beats);
        nb_elems = nb_last ? ELEM_W'(vl_q - (XLEN'(nb) << epb_shift)) : ELEM_W'(epb);
    end

    // Main sequencer: instruction intake, configuration update, vl writeback and beat walking
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state       <= ST_IDLE;
            vl_q        <= '0;
            vtype_q     <= {1'b1, {(XLEN-1){1'b0}}};
            avl_q       <= '0;
            req_vtype_q <= '0;
            rs1_x0_q    <= 1'b0;
            rd_x0_q     <= 1'b0;
            vd_q        <= '0;
            vs1_q       <= '0;
            vs2_q       <= '0;
            wb_valid    <= 1'b0;
            beat_valid  <= 1'b0;
            beat_cnt    <= '0;
            beat_last   <= 1'b0;
            beat_vd     <= '0;
            beat_vs1    <= '0;
            beat_vs2    <= '0;
            beat_sub    <= '0;
            beat_elems  <= '0;
            inst_done   <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            inst_done <= 1'b0;
            illegal   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (inst_valid) begin
                        avl_q       <= avl_i;
                        req_vtype_q <= vtype_i[XLEN-2:0];
                        rs1_x0_q    <= rs1_x0;
                        rd_x0_q     <= rd_x0;
                        vd_q        <= vd_i;
                        vs1_q       <= vs1_i;
                        vs2_q       <= vs2_i;
                        if (is_conf) begin
                            state <= ST_CONF;
                        end else if (vtype_q[XLEN-1] || (vl_q == '0)) begin
                            inst_done <= 1'b1;
                            illegal   <= vtype_q[XLEN-1];
                        end else begin
                            state      <= ST_EXEC;
                            beat_valid <= 1'b1;
                            beat_cnt   <= nb;
                            beat_last  <= nb_last;
                            beat_vd    <= nb_vd;
                            beat_vs1   <= nb_vs1;
                            beat_vs2   <= nb_vs2;
                            beat_sub   <= nb_sub;
                            beat_elems <= nb_elems;
                        end
                    end
                end
                ST_CONF: begin
                    vl_q     <= conf_vl;
                    vtype_q  <= conf_vill ? {1'b1, {(XLEN-1){1'b0}}} : {1'b0, req_vtype_q};
                    wb_valid <= 1'b1;
                    state    <= ST_WB;
                end
                ST_WB: begin
                    if (wb_ready) begin
                        wb_valid  <= 1'b0;
                        inst_done <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    if (beat_ready) begin
                        if (beat_last) begin
                            beat_valid <= 1'b0;
                            inst_done  <= 1'b1;
                            state      <= ST_IDLE;
                        end else begin
                            beat_cnt   <= nb;
                            beat_last  <= nb_last;
                            beat_vd    <= nb_vd;
                            beat_vs1   <= nb_vs1;
                            beat_vs2   <= nb_vs2;
                            beat_sub   <= nb_sub;
                            beat_elems <= nb_elems;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef VEC_SEQ_PERF_EN
    // Count accepted beats and cycles the datapath held a presented beat back
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            perf_beats  <= '0;
            perf_stalls <= '0;
        end else begin
            if (beat_valid && beat_ready) begin
                perf_beats <= perf_beats + 32'd1;
            end
            if (beat_valid && !beat_ready) begin
                perf_stalls <= perf_stalls + 32'd1;
            end
        end
    end
`else
    assign perf_beats  = '0;
    assign perf_stalls = '0;
`endif

endmodule

// File: doc/vec_seq_ctrl.md
Name: vec_seq_ctrl

Overview:
Sequencing controller behind the vector decoder. It holds the architectural vl/vtype state and executes configuration instructions (vsetvli/vsetivli/vsetvl), including VLMAX computation and the writeback of the new vl to the scalar core. It breaks each vector arithmetic instruction into datapath beats of LANE_W bits, walking register groups per LMUL, with valid/ready backpressure on both sides.

Parameters:
XLEN, 32, scalar/CSR width
VLEN, 512, bits per vector register
LANE_W, 128, datapath bits per beat; VLEN/LANE_W = BEATS_PER_REG (4)
VLMAX_ABS, 512, max elements (VLEN*8/8)

Ports:
clk  in  1  clock
n_rst  in  1  synchronous active-low reset
inst_valid  in  1  decoded vector instruction available
inst_ready  out  1  controller accepts instruction
is_conf  in  1  instruction is a configuration op (funct3=111)
avl_i  in  XLEN  requested AVL (rs1 value or uimm)
vtype_i  in  XLEN  requested vtype (zimm or rs2)
rs1_x0  in  1  rs1 field == x0 (not meaningful for vsetivli; decoder drives 0)
rd_x0  in  1  rd field == x0
vd_i, vs1_i, vs2_i  in  5 each  register addresses
vl_o  out  XLEN  current vl CSR
vtype_o  out  XLEN  current vtype CSR
wb_valid  out  1  new vl ready for scalar rd
wb_ready  in  1  scalar core accepts wb_data
wb_data  out  XLEN  new vl
beat_valid  out  1  beat presented to datapath
beat_ready  in  1  datapath accepts beat
beat_vd, beat_vs1, beat_vs2  out  5 each  register for current beat
beat_sub  out  2  beat index within register
beat_elems  out  $clog2(LANE_W/8)+1  active elements in beat
beat_sew  out  3  vsew of current op
inst_done  out  1  one-cycle pulse at instruction completion
illegal  out  1  one-cycle pulse, arith issued with vill=1
perf_beats, perf_stalls  out  32 each  see Optional Feature

Behaviour:
- Reset (n_rst=0 at posedge): state IDLE; vl_o=0; vtype_o={1'b1,'0} (vill set); all valid/pulse outputs 0; counters 0. Applies mid-operation: in-flight beats and pending wb are dropped.
- FSM: IDLE, CONF, WB, EXEC.
- IDLE: inst_ready=1. Handshake on inst_valid&inst_ready: latch inputs. If is_conf, go to CONF. Else if vill or vl_o==0, pulse inst_done (and illegal if vill) next cycle, stay IDLE. Else go to EXEC with beat counter=0.
- CONF (1 cycle):
  - vtype legality: vlmul in {000,001,010,011}, vsew in {000,001,010}, bits XLEN-2:8 zero. Otherwise vill=1, vl=0.
  - VLMAX = (VLEN<<vlmul)>>(vsew+3).
  - New vl = VLMAX if rs1_x0&!rd_x0; old vl if rs1_x0&rd_x0 (vtype still updated); else min(avl_i, VLMAX).
  - CSRs update at the end of CONF; go to WB.
- WB: wb_valid=1, wb_data=vl_o, held until wb_ready. Then pulse inst_done and go to IDLE. The WB handshake occurs even when rd_x0.
- EXEC:
  - EPB (elements per beat) = LANE_W>>(vsew+3).
  - Total beats = ceil(vl/EPB).
  - Beat b: beat_vX = vX_i + (b/BEATS_PER_REG), 5-bit wrap; beat_sub = b%BEATS_PER_REG; beat_elems = EPB, except on the last beat = vl-(b*EPB).
  - Outputs stable while beat_valid&!beat_ready. Advance on handshake.
  - Handshake on the last beat: inst_done pulses the next cycle and the FSM goes to IDLE. No bubble between beats.
- Latency: CONF→wb_valid is 2 cycles after acceptance; first beat_valid is 1 cycle after acceptance.

Optional Feature:
VEC_SEQ_PERF_EN:
- Defined: perf_beats increments on each beat handshake; perf_stalls increments on each cycle with beat_valid&!beat_ready. Both wrap at 2^32 and reset to 0.
- Undefined: counter logic is absent and both ports are tied to 0.

Decomposition:
- vec_seq_pkg: state enum, vtype field LSB/MSB constants (VLMUL, VSEW, VTA, VMA, VILL), SEW/LMUL encoding enums, BEATS_PER_REG.
- Sub-module vec_vlmax_calc: combinational vtype→{vlmax, vill}, reused by decode-side checks.

Test Plan:
1. conf avl=100, vsew=010, vlmul=000, rs1/rd≠x0 → vl=16, wb_data=16, inst_done after wb_ready.
2. conf avl=300, vsew=000, vlmul=011; arith vd=8, beat_ready=1 → 19 beats, beat_vd 8..12, last beat_sub=2, beat_elems=12, inst_done once.
3. conf vlmul=101 → vtype_o[31]=1, vl=0; then arith → illegal+inst_done pulse, no beat_valid.
4. EXEC vl=16 SEW32, beat_ready low 3 cycles at beat 2 → beat_sub=2, beat_vd unchanged 3 cycles; perf_stalls=3 when VEC_SEQ_PERF_EN defined.
5. conf rs1_x0=1, rd_x0=0, vsew=001, vlmul=001 → vl=64; then rs1_x0=rd_x0=1, vsew=010 → vl stays 64, vtype updated.
6. n_rst low during beat 5 of EXEC → next cycle beat_valid=0, state IDLE, vl_o=0, vtype_o=0x80000000.
